// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter.
//   CNT_W_DEF : default width of the period and high-time counters
//   state_t   : measurement FSM encoding (IDLE / ARM / MEASURE)
package period_meter_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous input.
// Ports:
//   clk   : sampling clock
//   rst   : asynchronous active-high reset, clears all flops
//   d     : asynchronous input
//   level : synchronized copy of d
//   rise  : high for one clk cycle when level goes from 0 to 1
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability filter and one-cycle history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// Measures the rise-to-rise period and the high time of an asynchronous
// signal, in clk cycles, continuously while start is held high.
// Build option: define PERIOD_METER_DUTY_EN to implement the high-time
// counter; without it high_time is tied to 0.
// Ports:
//   clk       : clock, all state changes on its rising edge
//   rst       : asynchronous active-high reset
//   start     : 1 enables measurement, 0 forces idle and clears the counters
//   sig_in    : signal under measurement (asynchronous to clk)
//   period    : last measured rise-to-rise interval
//   high_time : cycles sig_in was high within the last measured period
//   valid     : one-cycle pulse when period/high_time update
//   overflow  : sticky, set when the counter saturates before the next rise
//   busy      : 1 whenever the FSM is not IDLE
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_rise;
  logic             w_sat;
  logic             w_load;
  logic             w_inc;
  logic             w_clr;
  logic             w_capture;
  logic             w_ovf_set;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_overflow;
  logic             r_busy;

`ifdef PERIOD_METER_DUTY_EN
  logic             w_level;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] r_high_time;
`else
  logic             w_level_unused;
`endif

  // Input synchronization and rise detection
  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
`ifdef PERIOD_METER_DUTY_EN
    .level (w_level),
`else
    .level (w_level_unused),
`endif
    .rise  (w_rise)
  );

  // Counter has reached its largest representable value
  assign w_sat = (r_cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start=0 overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (!start) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (w_rise) w_state_nxt = MEASURE;
        // A rise coinciding with saturation is a normal capture
        MEASURE: if (!w_rise && w_sat) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath control decode
  always_comb begin
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_clr     = 1'b0;
    w_capture = 1'b0;
    w_ovf_set = 1'b0;
    if (!start) begin
      w_clr = 1'b0 | 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_clr = 1'b1;
        end
        ARM: begin
          if (w_rise) begin
            w_load = 1'b1;
          end else begin
            w_clr = 1'b1;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_capture = 1'b1;
            w_load    = 1'b1;
          end else if (w_sat) begin
            w_ovf_set = 1'b1;
            w_clr     = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
        default: begin
          w_clr = 1'b1;
        end
      endcase
    end
  end

  // Period counter: the rise cycle itself counts as cycle 1
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_load) begin
      w_cnt_nxt = CNT_ONE;
    end else if (w_inc) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (w_clr) begin
      w_cnt_nxt = '0;
    end
  end

  // Counter, result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_capture;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_capture) begin
        r_period <= r_cnt;
      end
      // Sticky until start drops
      r_overflow <= start & (r_overflow | w_ovf_set);
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  // High-time counter; never exceeds r_cnt, so it cannot wrap
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (w_load) begin
      w_hcnt_nxt = CNT_ONE;
    end else if (w_inc) begin
      w_hcnt_nxt = r_hcnt + CNT_W'(w_level);
    end else if (w_clr) begin
      w_hcnt_nxt = '0;
    end
  end

  // High-time registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_high_time <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      if (w_capture) begin
        r_high_time <= r_hcnt;
      end
    end
  end

  assign high_time = r_high_time;
`else
  assign high_time = '0;
`endif

  assign period   = r_period;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign busy     = r_busy;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: an 8-bit instance for normal
// measurement/reset checks and a 4-bit instance for saturation checks.
module tb_period_meter;
  import period_meter_pkg::*;

`ifdef PERIOD_METER_DUTY_EN
  localparam int unsigned DUTY = 1;
`else
  localparam int unsigned DUTY = 0;
`endif

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned gap;   // expected cycles since previous valid, 0 = unchecked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sig8, valid8, ovf8, busy8;
  logic [7:0] period8, high8;
  logic       start4, sig4, valid4, ovf4, busy4;
  logic [3:0] period4, high4;

  exp_t        q8[$];
  exp_t        q4[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last8    = 0;
  int unsigned last4    = 0;

  always #5 clk = ~clk;

  period_meter dut8 (
    .clk(clk), .rst(rst), .start(start8), .sig_in(sig8),
    .period(period8), .high_time(high8), .valid(valid8),
    .overflow(ovf8), .busy(busy8)
  );

  period_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sig_in(sig4),
    .period(period4), .high_time(high4), .valid(valid4),
    .overflow(ovf4), .busy(busy4)
  );

  function automatic int unsigned hexp(input int unsigned h);
    return (DUTY != 0) ? h : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push8(input int unsigned p, input int unsigned h, input int unsigned g);
    exp_t e;
    e = '{p, hexp(h), g};
    q8.push_back(e);
  endtask

  task automatic push4(input int unsigned p, input int unsigned h, input int unsigned g);
    exp_t e;
    e = '{p, hexp(h), g};
    q4.push_back(e);
  endtask

  // Advance one cycle, then score any valid pulse against the queues
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (valid8 === 1'b1) begin
      chk("sb8_entry", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("period8", 32'(period8), e.period);
        chk("high8", 32'(high8), e.high);
        if (e.gap != 0) chk("gap8", 32'(cyc - last8), e.gap);
      end
      last8 = cyc;
    end
    if (valid4 === 1'b1) begin
      chk("sb4_entry", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("period4", 32'(period4), e.period);
        chk("high4", 32'(high4), e.high);
        if (e.gap != 0) chk("gap4", 32'(cyc - last4), e.gap);
      end
      last4 = cyc;
    end
  endtask

  task automatic drive8(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      sig8 = 1'b1;
      repeat (hi) tick();
      sig8 = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic drive4(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      sig4 = 1'b1;
      repeat (hi) tick();
      sig4 = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start8 = 1'b0; sig8 = 1'b0; start4 = 1'b0; sig4 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_period8", 32'(period8), 0);
    chk("rst_high8",   32'(high8),   0);
    chk("rst_valid8",  32'(valid8),  0);
    chk("rst_ovf8",    32'(ovf8),    0);
    chk("rst_busy8",   32'(busy8),   0);
    chk("rst_period4", 32'(period4), 0);
    chk("rst_busy4",   32'(busy4),   0);
    tick();
    tick();
    #2 rst = 1'b0;

    // Rises while start=0 are ignored
    drive8(1, 3, 2);
    chk("idle_busy8", 32'(busy8), 0);
    chk("idle_period8", 32'(period8), 0);

    // Divide-by-3 source
    start8 = 1'b1;
    tick();
    push8(3, 1, 0);
    for (int k = 0; k < 6; k++) push8(3, 1, 3);
    drive8(1, 2, 8);
    repeat (6) tick();
    chk("div3_drained", 32'(q8.size()), 0);
    chk("div3_busy", 32'(busy8), 1);

    // start dropped mid-MEASURE
    start8 = 1'b0;
    tick();
    chk("stop_busy8", 32'(busy8), 0);
    chk("stop_valid8", 32'(valid8), 0);
    chk("stop_ovf8", 32'(ovf8), 0);
    chk("stop_period8", 32'(period8), 3);
    tick();
    chk("stop_hold_period8", 32'(period8), 3);
    chk("stop_hold_high8", 32'(high8), hexp(1));

    // 10-cycle period, 4 cycles high
    start8 = 1'b1;
    tick();
    push8(10, 4, 0);
    for (int k = 0; k < 3; k++) push8(10, 4, 10);
    drive8(4, 6, 5);
    repeat (6) tick();
    chk("p10_drained", 32'(q8.size()), 0);
    chk("p10_period8", 32'(period8), 10);
    start8 = 1'b0;
    tick();

    // 4-bit instance: capture a 5-cycle period, then saturate
    start4 = 1'b1;
    tick();
    push4(5, 1, 0);
    drive4(1, 4, 2);
    for (int i = 0; i < 40 && ovf4 !== 1'b1; i++) tick();
    chk("ovf4_set", 32'(ovf4), 1);
    chk("ovf4_latency", 32'(cyc - last4), 15);
    chk("ovf4_busy", 32'(busy4), 1);
    chk("ovf4_state", 32'(dut4.r_state), 32'(ARM));
    chk("ovf4_period", 32'(period4), 5);
    chk("ovf4_drained", 32'(q4.size()), 0);
    repeat (3) tick();
    chk("ovf4_sticky", 32'(ovf4), 1);
    chk("ovf4_period_hold", 32'(period4), 5);
    start4 = 1'b0;
    tick();
    chk("ovf4_cleared", 32'(ovf4), 0);
    chk("ovf4_idle", 32'(busy4), 0);
    chk("ovf4_period_kept", 32'(period4), 5);

    // Rise in the same cycle the counter reaches all-ones
    start4 = 1'b1;
    tick();
    push4(15, 1, 0);
    push4(15, 1, 15);
    drive4(1, 14, 2);
    drive4(1, 5, 1);
    chk("sat_rise_drained", 32'(q4.size()), 0);
    chk("sat_rise_period4", 32'(period4), 15);
    chk("sat_rise_ovf4", 32'(ovf4), 0);

    // Asynchronous reset mid-measurement
    start8 = 1'b1;
    tick();
    push8(3, 1, 0);
    push8(3, 1, 3);
    drive8(1, 2, 3);
    repeat (2) tick();
    chk("pre_rst_drained", 32'(q8.size()), 0);
    chk("pre_rst_busy8", 32'(busy8), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_period8", 32'(period8), 0);
    chk("arst_high8",   32'(high8),   0);
    chk("arst_valid8",  32'(valid8),  0);
    chk("arst_ovf8",    32'(ovf8),    0);
    chk("arst_busy8",   32'(busy8),   0);
    chk("arst_period4", 32'(period4), 0);
    chk("arst_busy4",   32'(busy4),   0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    tick();
    push8(3, 1, 0);
    push8(3, 1, 3);
    push8(3, 1, 3);
    drive8(1, 2, 4);
    repeat (6) tick();
    chk("post_rst_drained", 32'(q8.size()), 0);
    chk("post_rst_period8", 32'(period8), 3);
    start8 = 1'b0;
    start4 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, which sets the width of the period and high-time counters.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: 1 enables measurement; 0 forces idle and clears the measurement.
REQ-005 SHALL have port sig_in, input, 1 bit: the signal being measured (e.g. a divided clock); may be asynchronous to clk.
REQ-006 SHALL have port period, output, CNT_W bits: the last measured rising-edge-to-rising-edge interval, in clk cycles.
REQ-007 SHALL have port high_time, output, CNT_W bits: clk cycles sig_in was high within the last measured period.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag set when the counter saturates before the next rising edge.
REQ-010 SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer; rise = sync_q & ~sync_prev; rise is asserted 2 cycles after sig_in is first sampled high.
REQ-012 SHALL implement states IDLE, ARM and MEASURE.
REQ-013 SHALL, in any state with start=0, go to IDLE next cycle: cnt=0, hcnt=0, valid=0, overflow=0; period and high_time hold their values.
REQ-014 SHALL go IDLE->ARM when start=1; rises seen in IDLE are ignored.
REQ-015 SHALL go ARM->MEASURE on rise, loading cnt=1 and hcnt=1; no valid is produced in this transition.
REQ-016 SHALL, in MEASURE without rise, set cnt=cnt+1 and set hcnt=hcnt+sync_q.
REQ-017 SHALL, in MEASURE on rise, load period<=cnt and high_time<=hcnt, pulse valid=1 for 1 cycle, reload cnt=1 and hcnt=1, and stay in MEASURE (continuous measurement).
REQ-018 SHALL give valid 1 cycle of latency after rise; period equals the rise-to-rise spacing exactly (e.g. a divide-by-3 source gives period=3).
REQ-019 SHALL, when cnt reaches all-ones (2^CNT_W-1) without rise, set overflow=1, go MEASURE->ARM, and leave period unchanged.
REQ-020 SHALL keep overflow set until start=0 or rst.
REQ-021 SHALL give rise priority when rise and saturation occur in the same cycle: treat it as a normal capture, with no overflow.
REQ-022 SHALL keep all counters unsigned and non-wrapping; no value above 2^CNT_W-1 is ever produced.

Reset
REQ-023 SHALL, on rst, immediately set state=IDLE, sync flops=0, cnt=0, hcnt=0, period=0, high_time=0, valid=0, overflow=0, busy=0.
REQ-024 SHALL, after rst is released, restart from IDLE and discard any measurement that was in progress.

Configuration
REQ-025 SHALL use macro PERIOD_METER_DUTY_EN; when it is defined, hcnt and high_time are implemented as specified above.
REQ-026 SHALL, when PERIOD_METER_DUTY_EN is undefined, omit hcnt logic and tie high_time to 0; all other behaviour is unchanged.

Structure
REQ-027 SHALL place the state typedef (IDLE/ARM/MEASURE encoding) and the default CNT_W constant in a shared package, period_meter_pkg.
REQ-028 SHALL place the synchronizer and rise detector in a sub-module, edge_sync (ports clk, rst, d, level, rise).

Verification
REQ-029 SHALL test a divide-by-3 source (1 cycle high, 2 cycles low), start=1: from the 2nd rise onward, valid every 3 cycles with period=3, high_time=1.
REQ-030 SHALL test sig_in with a 10-cycle period and 4 cycles high: period=10, high_time=4; without the macro, high_time=0.
REQ-031 SHALL test CNT_W=4 with sig_in held low after the first rise: overflow=1 at cnt=15, state=ARM, period unchanged.
REQ-032 SHALL test start deasserted mid-MEASURE: next cycle busy=0, valid=0, overflow=0; period holds its last value.
REQ-033 SHALL test rst asserted mid-measurement, asynchronous to clk: all outputs 0 immediately; after release, the first valid arrives only after 2 rises.
REQ-034 SHALL test a rise in the same cycle that cnt reaches all-ones: valid=1, period=2^CNT_W-1, overflow stays 0.
